// File: rtl/led_env_pkg.sv
// Shared encodings for the LED envelope sequencer: state codes and level width.
package led_env_pkg;

  localparam int LEVEL_W = 8;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/led_envelope_ctrl_tick_gen.sv
// Envelope tick prescaler: counts 0..TICK_DIV-1, tick high on the last count.
module env_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/led_envelope_ctrl.sv
// ADSR envelope sequencer feeding pwm_led.duty_cycle.
// Define LED_ENV_GAMMA_EN for a squared (perceptual) duty curve with one extra register stage.
module led_envelope_ctrl
  import led_env_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int PEAK_LEVEL = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_on,
  input  logic               note_off,
  input  logic [LEVEL_W-1:0] attack_step,
  input  logic [LEVEL_W-1:0] decay_step,
  input  logic [LEVEL_W-1:0] sustain_level,
  input  logic [LEVEL_W-1:0] release_step,
  output logic [LEVEL_W-1:0] duty_cycle,
  output logic               busy,
  output logic [2:0]         env_state
);

  localparam logic [LEVEL_W-1:0] PEAK = LEVEL_W'(PEAK_LEVEL);

  // A zero step means "jump straight to the target on the next tick".
  function automatic logic [LEVEL_W-1:0] add_sat_peak(input logic [LEVEL_W-1:0] lvl,
                                                      input logic [LEVEL_W-1:0] step);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, lvl} + {1'b0, step};
    if (step == '0 || sum >= {1'b0, PEAK}) return PEAK;
    return sum[LEVEL_W-1:0];
  endfunction

  function automatic logic [LEVEL_W-1:0] sub_floor(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [LEVEL_W-1:0] step,
                                                   input logic [LEVEL_W-1:0] floor_lvl);
    logic signed [LEVEL_W:0] diff;
    diff = $signed({1'b0, lvl}) - $signed({1'b0, step});
    if (step == '0 || diff <= $signed({1'b0, floor_lvl})) return floor_lvl;
    return diff[LEVEL_W-1:0];
  endfunction

  env_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] sus_lvl;
  logic               tick, presc_clr;

  env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (presc_clr),
    .tick_o  (tick)
  );

  assign sus_lvl = (sustain_level > PEAK) ? PEAK : sustain_level;

  // Events take priority over ticks; a cycle with an event never moves the level.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    presc_clr = 1'b0;
    if (note_on) begin
      state_d   = ENV_ATTACK;
      presc_clr = 1'b1;
    end else if (note_off && (state_q inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})) begin
      state_d = ENV_RELEASE;
    end else if (tick) begin
      case (state_q)
        ENV_ATTACK: begin
          level_d = add_sat_peak(level_q, attack_step);
          if (level_d == PEAK) state_d = ENV_DECAY;
        end
        ENV_DECAY: begin
          level_d = sub_floor(level_q, decay_step, sus_lvl);
          if (level_d == sus_lvl) state_d = ENV_SUSTAIN;
        end
        ENV_SUSTAIN: level_d = sus_lvl;
        ENV_RELEASE: begin
          level_d = sub_floor(level_q, release_step, '0);
          if (level_d == '0) state_d = ENV_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENV_IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

`ifdef LED_ENV_GAMMA_EN
  function automatic logic [LEVEL_W-1:0] gamma_sq(input logic [LEVEL_W-1:0] lvl);
    logic [2*LEVEL_W-1:0] sq;
    sq = lvl * lvl;
    if (lvl == '1) return '1;
    return sq[2*LEVEL_W-1:LEVEL_W];
  endfunction

  logic [LEVEL_W-1:0] gamma_p0, duty_q;

  // Stage p0: squared level; stage p1: duty output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      gamma_p0 <= '0;
      duty_q   <= '0;
    end else begin
      gamma_p0 <= gamma_sq(level_q);
      duty_q   <= gamma_p0;
    end
  end
`else
  logic [LEVEL_W-1:0] duty_q;

  always_ff @(posedge clk) begin
    if (reset) duty_q <= '0;
    else       duty_q <= level_q;
  end
`endif

  assign duty_cycle = duty_q;
  assign busy       = (state_q != ENV_IDLE);
  assign env_state  = state_q;

endmodule

// File: tb/tb_led_envelope_ctrl.sv
// Scoreboard bench for led_envelope_ctrl with TICK_DIV=4, PEAK_LEVEL=255, default build.
module tb_led_envelope_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       note_on, note_off;
  logic [7:0] attack_step, decay_step, sustain_level, release_step;
  logic [7:0] duty_cycle;
  logic       busy;
  logic [2:0] env_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prev_duty = 8'd0;
  logic [7:0] mon_exp;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  led_envelope_ctrl #(.TICK_DIV(4), .PEAK_LEVEL(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .note_on       (note_on),
    .note_off      (note_off),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .duty_cycle    (duty_cycle),
    .busy          (busy),
    .env_state     (env_state)
  );

  // Monitor: every change of duty_cycle must match the next expected value.
  always @(negedge clk) begin
    if (mon_en && duty_cycle !== prev_duty) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL duty_unexpected got=%0d required=none", duty_cycle);
      end else begin
        mon_exp = exp_q.pop_front();
        if (duty_cycle !== mon_exp) begin
          failures++;
          $display("FAIL duty_seq got=%0d required=%0d", duty_cycle, mon_exp);
        end
      end
      prev_duty = duty_cycle;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic pulse(input bit on, input bit off);
    @(negedge clk);
    note_on  = on;
    note_off = off;
    @(posedge clk);
    @(negedge clk);
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s got=%0d_pending required=0_pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic first_tick_latency(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (duty_cycle == prev_duty && n < 50);
    check(name, n, 5);
  endtask

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  initial begin
    reset = 1'b1; note_on = 1'b0; note_off = 1'b0;
    attack_step = 8'd0; decay_step = 8'd0; sustain_level = 8'd0; release_step = 8'd0;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    check("reset_duty", duty_cycle, 0);
    check("reset_busy", busy, 0);
    check("reset_state", env_state, 0);
    prev_duty = duty_cycle;
    mon_en    = 1'b1;

    // Full attack/decay into sustain
    attack_step = 8'd64; decay_step = 8'd32; sustain_level = 8'd128; release_step = 8'd100;
    foreach (exp_q[i]) ;
    push(8'd64); push(8'd128); push(8'd192); push(8'd255);
    push(8'd223); push(8'd191); push(8'd159); push(8'd128);
    pulse(1'b1, 1'b0);
    first_tick_latency("first_tick_latency");
    wait_empty("ad_sequence", 100);
    repeat (2) @(negedge clk); #1;
    check("sustain_state", env_state, 3);
    check("sustain_busy", busy, 1);

    // Release to idle
    push(8'd28); push(8'd0);
    pulse(1'b0, 1'b1);
    #1;
    check("release_state", env_state, 4);
    wait_empty("release_sequence", 60);
    repeat (2) @(negedge clk); #1;
    check("idle_state", env_state, 0);
    check("idle_busy", busy, 0);

    // Release from mid-attack level 48
    attack_step = 8'd16; release_step = 8'd20;
    push(8'd16); push(8'd32); push(8'd48);
    pulse(1'b1, 1'b0);
    repeat (12) @(posedge clk);
    push(8'd28); push(8'd8); push(8'd0);
    pulse(1'b0, 1'b1);
    #1;
    check("mid_release_state", env_state, 4);
    check("mid_release_level", duty_cycle, 48);
    wait_empty("mid_release_sequence", 60);
    repeat (2) @(negedge clk); #1;
    check("mid_release_idle", env_state, 0);

    // note_on + note_off together, instant attack, then reset during decay
    attack_step = 8'd0; decay_step = 8'd32; sustain_level = 8'd128;
    push(8'd255); push(8'd223); push(8'd191);
    pulse(1'b1, 1'b1);
    #1;
    check("on_wins_state", env_state, 1);
    wait_empty("instant_attack_decay", 60);
    check("decay_before_reset", env_state, 2);
    push(8'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    check("abort_state", env_state, 0);
    check("abort_busy", busy, 0);
    check("abort_duty", duty_cycle, 0);
    wait_empty("abort_duty_seen", 4);

    // Prescaler restarted; then sustain equal to peak
    attack_step = 8'd64; sustain_level = 8'd128;
    push(8'd64);
    pulse(1'b1, 1'b0);
    first_tick_latency("tick_after_reset");
    wait_empty("post_reset_attack", 4);
    attack_step = 8'd0; sustain_level = 8'd255;
    push(8'd255);
    wait_empty("peak_jump", 20);
    repeat (6) @(negedge clk); #1;
    check("peak_eq_sustain_state", env_state, 3);
    check("peak_eq_sustain_duty", duty_cycle, 255);

    // Instant release
    release_step = 8'd0;
    push(8'd0);
    pulse(1'b0, 1'b1);
    wait_empty("instant_release", 20);
    repeat (2) @(negedge clk); #1;
    check("instant_release_idle", env_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
